// File: rtl/flit_assembler.sv
// flit_assembler: packs NoC flits into 4-slot packet words, zero-filling unused slots
// and dropping malformed flit sequences with a one-cycle error pulse.
module flit_assembler #(
    parameter int WIDTH_PKT        = 600,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int ADDRESS_WIDTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH_PKT/4-1:0] i_flit_in,
    input  logic                 i_flit_valid_in,
    output logic                 i_flit_ready_out,
    output logic [WIDTH_PKT-1:0] o_packet_out,
    output logic                 o_valid_out,
    input  logic                 o_ready_in,
    output logic                 o_err_out
);

    localparam int WIDTH_FLIT = WIDTH_PKT / 4;

    // VC and address fields are carried through verbatim; they only constrain the flit layout.
    if ((WIDTH_PKT % 4) != 0 || WIDTH_FLIT < 3 + VC_ADDRESS_WIDTH + ADDRESS_WIDTH) begin : g_param_check
        $error("flit_assembler: WIDTH_PKT must be divisible by 4 and hold the flit header fields");
    end

    logic [WIDTH_PKT-1:0] asm_q, asm_d;
    logic [WIDTH_PKT-1:0] pkt_q, pkt_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;

    logic                 move;
    logic                 accept;
    logic                 is_head;
    logic                 is_tail;
    logic                 write_en;
    logic [1:0]           slot;

    always_comb begin
        move     = done_q & (~valid_q | o_ready_in);
        accept   = i_flit_valid_in & (~done_q | move);
        is_head  = i_flit_in[WIDTH_FLIT-2];
        is_tail  = i_flit_in[WIDTH_FLIT-3];

        // A move empties A in the same cycle, so a flit accepted now sees a fresh assembly.
        asm_d    = move ? '0 : asm_q;
        cnt_d    = move ? 3'd0 : cnt_q;
        done_d   = move ? 1'b0 : done_q;
        err_d    = 1'b0;
        write_en = 1'b0;
        slot     = 2'd0;

        if (accept) begin
            if (is_head) begin
                err_d    = (cnt_d != 3'd0);
                asm_d    = '0;
                write_en = 1'b1;
                slot     = 2'd0;
                cnt_d    = 3'd1;
                done_d   = is_tail;
            end else if (cnt_d == 3'd0) begin
                err_d    = 1'b1;
            end else begin
                write_en = 1'b1;
                slot     = cnt_d[1:0];
                done_d   = is_tail | (cnt_d == 3'd3);
                cnt_d    = cnt_d + 3'd1;
            end
        end

        if (write_en) begin
            for (int k = 0; k < 4; k++) begin
                if (slot == 2'(k)) begin
                    asm_d[WIDTH_PKT-1-k*WIDTH_FLIT -: WIDTH_FLIT] = i_flit_in;
                end
            end
        end

        pkt_d   = pkt_q;
        valid_d = valid_q;
        if (move) begin
            pkt_d   = asm_q;
            valid_d = 1'b1;
        end else if (valid_q & o_ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q   <= '0;
            cnt_q   <= 3'd0;
            done_q  <= 1'b0;
            pkt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pkt_q   <= pkt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Ready depends on o_ready_in combinationally so a full A can hand off and refill in one cycle.
    assign i_flit_ready_out = ~done_q | move;
    assign o_packet_out     = pkt_q;
    assign o_valid_out      = valid_q;
    assign o_err_out        = err_q;

endmodule

// File: tb/tb_flit_assembler.sv
// Scoreboard-based bench for flit_assembler: expected packets are queued as flits are
// driven and compared when the DUT hands a packet downstream.
module tb_flit_assembler;

    localparam int WP = 600;
    localparam int WF = WP / 4;

    logic          clk;
    logic          rst;
    logic [WF-1:0] i_flit_in;
    logic          i_flit_valid_in;
    logic          i_flit_ready_out;
    logic [WP-1:0] o_packet_out;
    logic          o_valid_out;
    logic          o_ready_in;
    logic          o_err_out;

    int passCount  = 0;
    int checkCount = 0;
    int errCount   = 0;
    logic [WP-1:0] expQ[$];

    flit_assembler #(
        .WIDTH_PKT(WP),
        .VC_ADDRESS_WIDTH(1),
        .ADDRESS_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_flit_in(i_flit_in),
        .i_flit_valid_in(i_flit_valid_in),
        .i_flit_ready_out(i_flit_ready_out),
        .o_packet_out(o_packet_out),
        .o_valid_out(o_valid_out),
        .o_ready_in(o_ready_in),
        .o_err_out(o_err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WF-1:0] mk(input logic sop, input logic eop, input logic [31:0] data);
        logic [WF-1:0] f;
        f = '0;
        f[WF-1] = 1'b1;
        f[WF-2] = sop;
        f[WF-3] = eop;
        f[100 +: 32] = ~data;
        f[31:0] = data;
        return f;
    endfunction

    function automatic logic [WP-1:0] pk(input logic [WF-1:0] a, input logic [WF-1:0] b,
                                         input logic [WF-1:0] c, input logic [WF-1:0] d);
        return {a, b, c, d};
    endfunction

    // Outputs and handshake inputs are stable at the falling edge; delivered packets are scored here.
    always @(negedge clk) begin
        if (!rst && o_valid_out && o_ready_in) begin
            checkCount++;
            if (expQ.size() == 0) begin
                $display("[TB] FAIL unexpected_packet got=%h expected=none", o_packet_out);
            end else begin
                logic [WP-1:0] exp;
                exp = expQ.pop_front();
                if (o_packet_out !== exp)
                    $display("[TB] FAIL packet_data got=%h expected=%h", o_packet_out, exp);
                else
                    passCount++;
            end
        end
        if (o_err_out) errCount++;
    end

    task automatic drive_flit(input logic [WF-1:0] f, output int waits);
        waits = 0;
        i_flit_in = f;
        i_flit_valid_in = 1'b1;
        @(negedge clk);
        while (!i_flit_ready_out && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!i_flit_ready_out) begin
            checkCount++;
            $display("[TB] FAIL accept_timeout got=ready0 expected=ready1");
        end
        @(posedge clk);
        #1;
        i_flit_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_flit_in = '0;
        i_flit_valid_in = 1'b0;
        o_ready_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if (o_valid_out !== 1'b0) $display("[TB] FAIL reset_valid got=%b expected=0", o_valid_out); else passCount++;
        checkCount++;
        if (o_err_out !== 1'b0) $display("[TB] FAIL reset_err got=%b expected=0", o_err_out); else passCount++;
        checkCount++;
        if (o_packet_out !== '0) $display("[TB] FAIL reset_packet got=%h expected=0", o_packet_out); else passCount++;
        rst = 1'b0;
        #1;
        checkCount++;
        if (i_flit_ready_out !== 1'b1) $display("[TB] FAIL reset_ready got=%b expected=1", i_flit_ready_out); else passCount++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_four_flit();
        logic [WF-1:0] f0, f1, f2, f3;
        int w;
        int errBefore;
        errBefore = errCount;
        o_ready_in = 1'b1;
        f0 = mk(1'b1, 1'b0, $urandom);
        f1 = mk(1'b0, 1'b0, $urandom);
        f2 = mk(1'b0, 1'b0, $urandom);
        f3 = mk(1'b0, 1'b1, $urandom);
        expQ.push_back(pk(f0, f1, f2, f3));
        drive_flit(f0, w);
        drive_flit(f1, w);
        drive_flit(f2, w);
        drive_flit(f3, w);
        checkCount++;
        if (o_valid_out !== 1'b0) $display("[TB] FAIL four_latency_early got=%b expected=0", o_valid_out); else passCount++;
        @(posedge clk);
        #1;
        checkCount++;
        if (o_valid_out !== 1'b1) $display("[TB] FAIL four_latency got=%b expected=1", o_valid_out); else passCount++;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if (errCount != errBefore) $display("[TB] FAIL four_err got=%0d expected=%0d", errCount, errBefore); else passCount++;
    endtask

    task automatic test_one_flit();
        logic [WF-1:0] f0;
        int w;
        o_ready_in = 1'b1;
        f0 = mk(1'b1, 1'b1, 32'h5A);
        expQ.push_back(pk(f0, '0, '0, '0));
        drive_flit(f0, w);
        @(posedge clk);
        #1;
        checkCount++;
        if (o_valid_out !== 1'b1) $display("[TB] FAIL one_valid got=%b expected=1", o_valid_out); else passCount++;
        checkCount++;
        if (o_packet_out[WP-WF-1:0] !== '0)
            $display("[TB] FAIL one_zero_slots got=%h expected=0", o_packet_out[WP-WF-1:0]);
        else passCount++;
        checkCount++;
        if ({o_packet_out[3*WF-1], o_packet_out[2*WF-1], o_packet_out[WF-1]} !== 3'b000)
            $display("[TB] FAIL one_slot_valid got=%b expected=000",
                     {o_packet_out[3*WF-1], o_packet_out[2*WF-1], o_packet_out[WF-1]});
        else passCount++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [WF-1:0] f[8];
        int w;
        int totalWaits;
        totalWaits = 0;
        o_ready_in = 1'b1;
        for (int i = 0; i < 8; i++) f[i] = mk((i % 4) == 0, (i % 4) == 3, $urandom);
        expQ.push_back(pk(f[0], f[1], f[2], f[3]));
        expQ.push_back(pk(f[4], f[5], f[6], f[7]));
        for (int i = 0; i < 8; i++) begin
            drive_flit(f[i], w);
            totalWaits += w;
        end
        checkCount++;
        if (totalWaits != 0) $display("[TB] FAIL b2b_stalls got=%0d expected=0", totalWaits); else passCount++;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [WF-1:0] a, b, c, d;
        logic [WP-1:0] p1, p2;
        int w;
        a = mk(1'b1, 1'b0, $urandom);
        b = mk(1'b0, 1'b1, $urandom);
        c = mk(1'b1, 1'b0, $urandom);
        d = mk(1'b0, 1'b1, $urandom);
        p1 = pk(a, b, '0, '0);
        p2 = pk(c, d, '0, '0);
        o_ready_in = 1'b0;
        expQ.push_back(p1);
        expQ.push_back(p2);
        drive_flit(a, w);
        drive_flit(b, w);
        drive_flit(c, w);
        drive_flit(d, w);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkCount++;
            if (o_valid_out !== 1'b1 || o_packet_out !== p1)
                $display("[TB] FAIL bp_hold cycle=%0d got_valid=%b got=%h expected=%h", i, o_valid_out, o_packet_out, p1);
            else passCount++;
            checkCount++;
            if (i_flit_ready_out !== 1'b0)
                $display("[TB] FAIL bp_ready cycle=%0d got=%b expected=0", i, i_flit_ready_out);
            else passCount++;
        end
        @(posedge clk);
        #1;
        o_ready_in = 1'b1;
        @(posedge clk);
        #1;
        checkCount++;
        if (o_valid_out !== 1'b1 || o_packet_out !== p2)
            $display("[TB] FAIL bp_second got_valid=%b got=%h expected=%h", o_valid_out, o_packet_out, p2);
        else passCount++;
        @(posedge clk);
        #1;
        checkCount++;
        if (o_valid_out !== 1'b0) $display("[TB] FAIL bp_drained got=%b expected=0", o_valid_out); else passCount++;
    endtask

    task automatic test_stray_body();
        int w;
        int errBefore;
        errBefore = errCount;
        o_ready_in = 1'b1;
        drive_flit(mk(1'b0, 1'b0, $urandom), w);
        checkCount++;
        if (o_err_out !== 1'b1) $display("[TB] FAIL stray_err_pulse got=%b expected=1", o_err_out); else passCount++;
        @(posedge clk);
        #1;
        checkCount++;
        if (o_err_out !== 1'b0) $display("[TB] FAIL stray_err_clear got=%b expected=0", o_err_out); else passCount++;
        repeat (3) @(posedge clk);
        #1;
        checkCount++;
        if (errCount - errBefore != 1) $display("[TB] FAIL stray_err_count got=%0d expected=1", errCount - errBefore); else passCount++;
        checkCount++;
        if (o_valid_out !== 1'b0) $display("[TB] FAIL stray_no_valid got=%b expected=0", o_valid_out); else passCount++;
    endtask

    task automatic test_head_restart();
        logic [WF-1:0] h1, b1, h2, b2, t2;
        int w;
        int errBefore;
        errBefore = errCount;
        o_ready_in = 1'b1;
        h1 = mk(1'b1, 1'b0, $urandom);
        b1 = mk(1'b0, 1'b0, $urandom);
        h2 = mk(1'b1, 1'b0, $urandom);
        b2 = mk(1'b0, 1'b0, $urandom);
        t2 = mk(1'b0, 1'b1, $urandom);
        expQ.push_back(pk(h2, b2, t2, '0));
        drive_flit(h1, w);
        drive_flit(b1, w);
        drive_flit(h2, w);
        drive_flit(b2, w);
        drive_flit(t2, w);
        repeat (4) @(posedge clk);
        #1;
        checkCount++;
        if (errCount - errBefore != 1) $display("[TB] FAIL restart_err_count got=%0d expected=1", errCount - errBefore); else passCount++;
    endtask

    task automatic test_reset_mid();
        logic [WF-1:0] f[4];
        int w;
        int errBefore;
        o_ready_in = 1'b1;
        errBefore = errCount;
        drive_flit(mk(1'b1, 1'b0, $urandom), w);
        drive_flit(mk(1'b0, 1'b0, $urandom), w);
        drive_flit(mk(1'b0, 1'b0, $urandom), w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkCount++;
        if (o_valid_out !== 1'b0) $display("[TB] FAIL midrst_valid got=%b expected=0", o_valid_out); else passCount++;
        checkCount++;
        if (i_flit_ready_out !== 1'b1) $display("[TB] FAIL midrst_ready got=%b expected=1", i_flit_ready_out); else passCount++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) f[i] = mk(i == 0, i == 3, $urandom);
        expQ.push_back(pk(f[0], f[1], f[2], f[3]));
        for (int i = 0; i < 4; i++) drive_flit(f[i], w);
        repeat (4) @(posedge clk);
        #1;
        checkCount++;
        if (errCount != errBefore) $display("[TB] FAIL midrst_err got=%0d expected=%0d", errCount, errBefore); else passCount++;
    endtask

    initial begin
        test_reset();
        test_four_flit();
        test_one_flit();
        test_back_to_back();
        test_backpressure();
        test_stray_body();
        test_head_restart();
        test_reset_mid();
        repeat (5) @(posedge clk);
        #1;
        checkCount++;
        if (expQ.size() != 0) $display("[TB] FAIL undelivered_packets got=%0d expected=0", expQ.size()); else passCount++;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/flit_assembler.md
# flit_assembler

Reassembles NoC flits, arriving one per cycle from the router output port, into full 4-flit-wide packet words for the fabric output port. It sits directly upstream of the SOP-aware depacketizer and drives its packet input with valid/ready. Each flit is placed in its packet slot, unused slots are zero-filled, and malformed flit sequences are dropped and flagged.

## Interface
- WIDTH_PKT, 600, packet word width; must be divisible by 4
- VC_ADDRESS_WIDTH, 1, VC field width inside each flit; carried through untouched
- ADDRESS_WIDTH, 4, destination address field width inside each flit; carried through untouched
- WIDTH_FLIT, WIDTH_PKT/4, derived localparam; not overridable

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_flit_in  in  WIDTH_FLIT  flit: [WIDTH_FLIT-1]=valid, [WIDTH_FLIT-2]=sop/head, [WIDTH_FLIT-3]=eop/tail, then VC, address, data
- i_flit_valid_in  in  1  i_flit_in is presented
- i_flit_ready_out  out  1  flit accepted when valid & ready
- o_packet_out  out  WIDTH_PKT  assembled packet; flit k in bits [WIDTH_PKT-1-k*WIDTH_FLIT -: WIDTH_FLIT]
- o_valid_out  out  1  o_packet_out holds a complete packet
- o_ready_in  in  1  downstream accepts when valid & ready
- o_err_out  out  1  one-cycle pulse: a flit was dropped or a partial packet was discarded

## Operation
- Two registers: assembly register A with slot count cnt (0..4) and done flag; output register O with o_valid_out.
- Accept = i_flit_valid_in & i_flit_ready_out. An accepted flit is written verbatim into slot cnt of A, and cnt increments.
- Packet closes (done<=1) when the accepted flit has its eop bit set, or when it is the 4th flit (cnt==3). Slots not written stay zero, so their per-flit valid bits read 0 downstream.
- Head with cnt==0: starts a packet. Head+eop in one flit: a 1-flit packet with slots 1..3 zero.
- Non-head flit with cnt==0: dropped, A unchanged, o_err_out pulses.
- Head flit with cnt>0: the partial packet is discarded, A is cleared, the head is written to slot 0 with cnt=1, and o_err_out pulses.
- move = done & (~o_valid_out | o_ready_in). On move, A is copied to O, o_valid_out<=1, A is cleared to zero, cnt<=0, done<=0.
- O drains on o_valid_out & o_ready_in without move: o_valid_out<=0. o_packet_out is held stable while valid & ~ready.
- i_flit_ready_out = ~done | move. This is combinational from o_ready_in and a documented exception. A flit accepted in the move cycle lands in the freshly cleared A at slot 0.
- The flit valid bit [WIDTH_FLIT-1] is not checked; it is copied as is.

## Timing
- Reset: A=0, cnt=0, done=0, O=0, o_valid_out=0, o_err_out=0. i_flit_ready_out=1 immediately as reset deasserts.
- Latency: closing flit accepted at cycle t, done=1 at t+1, move at t+1 if O is free, o_valid_out=1 at t+2.
- Throughput: back-to-back packets sustain one flit per cycle when o_ready_in is held high. No bubble, because ready stays high in the move cycle.
- Backpressure: while done=1 and O is full and o_ready_in=0, i_flit_ready_out=0 and A holds.
- Simultaneous drain of O and move in the same cycle: O takes A, and o_valid_out stays 1.
- o_err_out is registered and asserts in the cycle after the offending accept.
- Reset mid-packet: A and O are cleared asynchronously, and any partial or held packet is lost silently with no o_err_out.

## Test plan
- 4-flit packet: head, body, body, tail, consecutive, o_ready_in=1. Require o_valid_out=1 exactly 2 cycles after the tail, all 4 slots equal to the input flits, and o_err_out=0.
- 1-flit packet: flit with sop=eop=1, data 0x5A. Require slot 0 = flit, o_packet_out[WIDTH_PKT-WIDTH_FLIT-1:0]=0, and depacketizer o_valid_out[2:0]=0.
- Backpressure: two 2-flit packets back-to-back, o_ready_in=0 for 10 cycles. Require packet 1 held stable in O, packet 2 parked in A, and i_flit_ready_out=0 until o_ready_in rises. Then both are delivered in order on consecutive valid cycles.
- Stray body flit (sop=0) while idle. Require it dropped, o_err_out high for exactly 1 cycle, and no o_valid_out.
- Head after 2 flits of an open packet, then body and tail. Require the first partial discarded, one o_err_out pulse, and the delivered packet = new head+body+tail with slot 3 zero.
- Assert rst for 1 cycle after 3 flits of a packet. Require o_valid_out=0 and i_flit_ready_out=1. A following clean 4-flit packet is delivered correctly.
